chacha_block_core: RTL and testbench

Iterative ChaCha block-function engine built from four parallel quarter-round lanes. One QR step executes per cycle, so a half-round takes 4 cycles. Round count, word width, rotation amounts and feed-forward are parameters. Takes a 16-word state over a valid/ready input and returns the permuted (optionally feed-forward-added) state over a valid/ready output. It is the next stage of the mem_hash datapath above the standalone quarter-round pipeline.

---
 rtl/chacha_block_core.sv | 164 ++++++++++++++++
 tb/tb_chacha_block_core.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block engine: four quarter-round lanes advance one QR step per
// enabled cycle over a 16-word working state, with optional feed-forward of the input.
//
//   state | meaning
//   IDLE  | waiting for an input state, in_ready asserted while clk_en=1
//   RUN   | executing QR steps, 4 per half-round, ROUNDS half-rounds
//   FINAL | one cycle to register the (feed-forward) result
//   DONE  | result held on out_state until the output handshake
module chacha_block_core #(
    parameter int N        = 32,
    parameter int ROUNDS   = 8,
    parameter int R0       = 16,
    parameter int R1       = 12,
    parameter int R2       = 8,
    parameter int R3       = 7,
    parameter int FEED_FWD = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [16*N-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16*N-1:0] out_state,
    output logic            busy
);

    localparam int HW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [HW-1:0] LAST_HR = HW'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      step;
    logic [HW-1:0]   hround;
    logic [N-1:0]    x    [16];
    logic [N-1:0]    orig [16];
    logic            load, run_step, fin, out_take;
    logic            diag;
    logic [3:0]      ia [4];
    logic [3:0]      ib [4];
    logic [3:0]      ic [4];
    logic [3:0]      id [4];
    logic [N-1:0]    na [4];
    logic [N-1:0]    nb [4];
    logic [N-1:0]    nc [4];
    logic [N-1:0]    nd [4];

    function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int r);
        return (v << r) | (v >> (N - r));
    endfunction

    assign diag = hround[0];

    // Word index = {row, column}; diagonal rounds shift row k's column by k (mod 4).
    for (genvar g = 0; g < 4; g++) begin : g_lane
        localparam logic [1:0] L = 2'(g);
        logic [N-1:0] va, vb, vc, vd, sab, scd;

        assign ia[g] = {2'd0, L};
        assign ib[g] = {2'd1, L + (diag ? 2'd1 : 2'd0)};
        assign ic[g] = {2'd2, L + (diag ? 2'd2 : 2'd0)};
        assign id[g] = {2'd3, L + (diag ? 2'd3 : 2'd0)};

        assign va  = x[ia[g]];
        assign vb  = x[ib[g]];
        assign vc  = x[ic[g]];
        assign vd  = x[id[g]];
        assign sab = va + vb;
        assign scd = vc + vd;

        assign na[g] = step[0] ? va : sab;
        assign nc[g] = step[0] ? scd : vc;
        assign nd[g] = (step == 2'd0) ? rotl(vd ^ sab, R0) :
                       (step == 2'd2) ? rotl(vd ^ sab, R2) : vd;
        assign nb[g] = (step == 2'd1) ? rotl(vb ^ scd, R1) :
                       (step == 2'd3) ? rotl(vb ^ scd, R3) : vb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        run_step  = 1'b0;
        fin       = 1'b0;
        out_take  = 1'b0;
        case (state)
            IDLE: begin
                if (clk_en && in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (clk_en) begin
                    run_step = 1'b1;
                    if (step == 2'd3 && hround == LAST_HR) state_nxt = FINAL;
                end
            end
            FINAL: begin
                if (clk_en) begin
                    fin       = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (clk_en && out_ready) begin
                    out_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step      <= 2'd0;
            hround    <= '0;
            out_valid <= 1'b0;
            out_state <= '0;
            for (logic [4:0] i = 5'd0; i < 5'd16; i++) begin
                x[i[3:0]]    <= '0;
                orig[i[3:0]] <= '0;
            end
        end else begin
            if (load) begin
                step   <= 2'd0;
                hround <= '0;
                for (logic [4:0] i = 5'd0; i < 5'd16; i++) begin
                    x[i[3:0]]    <= in_state[i*N +: N];
                    orig[i[3:0]] <= in_state[i*N +: N];
                end
            end
            if (run_step) begin
                for (logic [2:0] g = 3'd0; g < 3'd4; g++) begin
                    x[ia[g[1:0]]] <= na[g[1:0]];
                    x[ib[g[1:0]]] <= nb[g[1:0]];
                    x[ic[g[1:0]]] <= nc[g[1:0]];
                    x[id[g[1:0]]] <= nd[g[1:0]];
                end
                step <= step + 2'd1;
                if (step == 2'd3) hround <= (hround == LAST_HR) ? '0 : hround + 1'b1;
            end
            if (fin) begin
                out_valid <= 1'b1;
                for (logic [4:0] i = 5'd0; i < 5'd16; i++) begin
                    out_state[i*N +: N] <= (FEED_FWD != 0) ? x[i[3:0]] + orig[i[3:0]] : x[i[3:0]];
                end
            end
            if (out_take) out_valid <= 1'b0;
        end
    end

    assign in_ready = clk_en && (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: three configurations checked against a word-level
// ChaCha reference model, plus handshake, stall, reset and throughput scenarios.
module tb_chacha_block_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clk_en;
    logic [511:0] in_state;
    logic         iv20, ir20, ov20, or20, bz20;
    logic         iv1,  ir1,  ov1,  or1,  bz1;
    logic         iv8,  ir8,  ov8,  or8,  bz8;
    logic [511:0] os20, os1, os8;

    int errors = 0;
    int checks = 0;

    chacha_block_core #(.N(32), .ROUNDS(20), .FEED_FWD(1)) u20 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv20), .in_ready(ir20),
        .in_state(in_state), .out_valid(ov20), .out_ready(or20), .out_state(os20), .busy(bz20));
    chacha_block_core #(.N(32), .ROUNDS(1), .FEED_FWD(0)) u1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv1), .in_ready(ir1),
        .in_state(in_state), .out_valid(ov1), .out_ready(or1), .out_state(os1), .busy(bz1));
    chacha_block_core #(.N(32), .ROUNDS(8), .FEED_FWD(1)) u8 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .in_valid(iv8), .in_ready(ir8),
        .in_state(in_state), .out_valid(ov8), .out_ready(or8), .out_state(os8), .busy(bz8));

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    // Reference: full quarter-rounds applied per half-round using the ChaCha index table.
    function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int rounds, input bit ff);
        logic [31:0]  w [16];
        logic [31:0]  a, b, c, d;
        int           q [8][4];
        logic [511:0] r;
        q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
              '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        for (int i = 0; i < 16; i++) w[i] = s[i*32 +: 32];
        for (int h = 0; h < rounds; h++) begin
            for (int l = 0; l < 4; l++) begin
                int row;
                row = (h % 2) * 4 + l;
                a = w[q[row][0]]; b = w[q[row][1]]; c = w[q[row][2]]; d = w[q[row][3]];
                a = a + b; d = rotl32(d ^ a, 16);
                c = c + d; b = rotl32(b ^ c, 12);
                a = a + b; d = rotl32(d ^ a, 8);
                c = c + d; b = rotl32(b ^ c, 7);
                w[q[row][0]] = a; w[q[row][1]] = b; w[q[row][2]] = c; w[q[row][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = ff ? w[i] + s[i*32 +: 32] : w[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] rfc_state();
        logic [31:0]  wv [16];
        logic [511:0] r;
        wv = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
               32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
               32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = wv[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input int sel, input logic v);
        case (sel)
            0:       iv20 = v;
            1:       iv1  = v;
            default: iv8  = v;
        endcase
    endtask

    function automatic logic get_ir(input int sel);
        case (sel)
            0:       return ir20;
            1:       return ir1;
            default: return ir8;
        endcase
    endfunction

    function automatic logic get_ov(input int sel);
        case (sel)
            0:       return ov20;
            1:       return ov1;
            default: return ov8;
        endcase
    endfunction

    function automatic logic [511:0] get_os(input int sel);
        case (sel)
            0:       return os20;
            1:       return os1;
            default: return os8;
        endcase
    endfunction

    // Offer one block, then count enabled edges after the accepting edge until out_valid.
    task automatic run_block(input int sel, input logic [511:0] s, input bit stall,
                             output logic [511:0] res, output int edges, output bit ok);
        clk_en   = 1'b1;
        in_state = s;
        set_iv(sel, 1'b1);
        #1;
        checks++;
        if (get_ir(sel) !== 1'b1) begin
            errors++;
            $display("FAIL run_in_ready sel=%0d got=%b want=1", sel, get_ir(sel));
        end
        tick();
        set_iv(sel, 1'b0);
        in_state = rand_state();
        edges = 0;
        ok    = 1'b0;
        res   = '0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            bit en;
            en     = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            clk_en = en;
            tick();
            if (en) edges++;
            if (get_ov(sel) === 1'b1) begin
                ok  = 1'b1;
                res = get_os(sel);
            end
        end
        clk_en = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_timeout sel=%0d no out_valid within budget", sel);
        end
    endtask

    task automatic test_reset();
        checks++; if (ov20 !== 1'b0 || ov1 !== 1'b0 || ov8 !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b%b%b want=000", ov20, ov1, ov8); end
        checks++; if (bz20 !== 1'b0 || bz1 !== 1'b0 || bz8 !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b%b%b want=000", bz20, bz1, bz8); end
        checks++; if (ir20 !== 1'b1 || ir1 !== 1'b1 || ir8 !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b%b%b want=111", ir20, ir1, ir8); end
        checks++; if (os20 !== '0 || os1 !== '0 || os8 !== '0) begin
            errors++; $display("FAIL reset_out_state nonzero got8=%h", os8); end
        clk_en = 1'b0;
        #1;
        checks++; if (ir8 !== 1'b0) begin
            errors++; $display("FAIL in_ready_clk_en_low got=%b want=0", ir8); end
        clk_en = 1'b1;
        #1;
    endtask

    task automatic test_rfc();
        logic [511:0] s, res, exp;
        int e; bit ok;
        s   = rfc_state();
        exp = chacha_ref(s, 20, 1'b1);
        run_block(0, s, 1'b0, res, e, ok);
        checks++; if (e !== 81) begin errors++; $display("FAIL rfc_latency got=%0d want=81", e); end
        checks++; if (res[31:0] !== 32'he4e7f110) begin
            errors++; $display("FAIL rfc_word0 got=%h want=e4e7f110", res[31:0]); end
        checks++; if (res[63:32] !== 32'h15593bd1) begin
            errors++; $display("FAIL rfc_word1 got=%h want=15593bd1", res[63:32]); end
        checks++; if (res[511:480] !== 32'h4e3c50a2) begin
            errors++; $display("FAIL rfc_word15 got=%h want=4e3c50a2", res[511:480]); end
        checks++; if (res !== exp) begin
            errors++; $display("FAIL rfc_full got=%h want=%h", res, exp); end
        tick();
    endtask

    task automatic test_single_round();
        logic [511:0] s, res, exp;
        int e; bit ok;
        s = '0;
        s[31:0] = 32'h11111111; s[159:128] = 32'h01020304;
        s[287:256] = 32'h9b8d6f43; s[415:384] = 32'h01234567;
        exp = '0;
        exp[31:0] = 32'hea2a92f4; exp[159:128] = 32'hcb1cf8ce;
        exp[287:256] = 32'h4581472e; exp[415:384] = 32'h5881c4bb;
        run_block(1, s, 1'b0, res, e, ok);
        checks++; if (e !== 5) begin errors++; $display("FAIL r1_latency got=%0d want=5", e); end
        checks++; if (res !== exp) begin errors++; $display("FAIL r1_vector got=%h want=%h", res, exp); end
        tick();
        s = rand_state();
        exp = chacha_ref(s, 1, 1'b0);
        run_block(1, s, 1'b0, res, e, ok);
        checks++; if (res !== exp) begin errors++; $display("FAIL r1_random got=%h want=%h", res, exp); end
        tick();
    endtask

    task automatic test_stall();
        logic [511:0] s, res, exp;
        int e; bit ok;
        s   = rfc_state();
        exp = chacha_ref(s, 20, 1'b1);
        run_block(0, s, 1'b1, res, e, ok);
        checks++; if (e !== 81) begin errors++; $display("FAIL stall_latency got=%0d want=81", e); end
        checks++; if (res !== exp) begin errors++; $display("FAIL stall_result got=%h want=%h", res, exp); end
        tick();
    endtask

    task automatic test_random_r8();
        logic [511:0] s, res, exp;
        int e; bit ok;
        for (int n = 0; n < 4; n++) begin
            s   = rand_state();
            exp = chacha_ref(s, 8, 1'b1);
            run_block(2, s, 1'b0, res, e, ok);
            checks++; if (e !== 33) begin errors++; $display("FAIL r8_latency n=%0d got=%0d want=33", n, e); end
            checks++; if (res !== exp) begin errors++; $display("FAIL r8_result n=%0d got=%h want=%h", n, res, exp); end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [511:0] s, res, exp, snap;
        int e; bit ok;
        or8 = 1'b0;
        s   = rand_state();
        exp = chacha_ref(s, 8, 1'b1);
        run_block(2, s, 1'b0, res, e, ok);
        checks++; if (res !== exp) begin errors++; $display("FAIL hold_result got=%h want=%h", res, exp); end
        snap = res;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (os8 !== snap) begin
                errors++; $display("FAIL hold_state k=%0d got=%h want=%h", k, os8, snap); end
            checks++; if (ov8 !== 1'b1 || ir8 !== 1'b0 || bz8 !== 1'b1) begin
                errors++; $display("FAIL hold_flags k=%0d got v/r/b=%b%b%b want=101", k, ov8, ir8, bz8); end
        end
        or8 = 1'b1;
        tick();
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++; $display("FAIL hold_release got v/r=%b%b want=01", ov8, ir8); end
    endtask

    task automatic test_midreset();
        logic [511:0] s, res, exp;
        int e; bit ok;
        clk_en   = 1'b1;
        in_state = rand_state();
        iv8      = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (21) tick();
        checks++; if (bz8 !== 1'b1 || ov8 !== 1'b0) begin
            errors++; $display("FAIL midreset_running got b/v=%b%b want=10", bz8, ov8); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ov8 !== 1'b0 || bz8 !== 1'b0) begin
            errors++; $display("FAIL midreset_flags got v/b=%b%b want=00", ov8, bz8); end
        checks++; if (os8 !== '0) begin
            errors++; $display("FAIL midreset_out_state got=%h want=0", os8); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        s   = rand_state();
        exp = chacha_ref(s, 8, 1'b1);
        run_block(2, s, 1'b0, res, e, ok);
        checks++; if (e !== 33) begin errors++; $display("FAIL midreset_latency got=%0d want=33", e); end
        checks++; if (res !== exp) begin errors++; $display("FAIL midreset_result got=%h want=%h", res, exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [511:0] sa, sb;
        logic [511:0] outs [2];
        int acc_t [2];
        int cyc, acc_n, out_n;
        sa = rand_state();
        sb = rand_state();
        cyc = 0; acc_n = 0; out_n = 0;
        outs[0] = '0; outs[1] = '0; acc_t[0] = 0; acc_t[1] = 0;
        or8 = 1'b1; clk_en = 1'b1;
        in_state = sa;
        iv8 = 1'b1;
        #1;
        for (int k = 0; k < 400 && out_n < 2; k++) begin
            bit will_acc;
            will_acc = iv8 && ir8;
            tick();
            cyc++;
            if (will_acc && acc_n < 2) begin
                acc_t[acc_n] = cyc;
                acc_n++;
                if (acc_n == 1) in_state = sb;
                else iv8 = 1'b0;
            end
            if (ov8 === 1'b1 && out_n < 2) begin
                outs[out_n] = os8;
                out_n++;
            end
        end
        iv8 = 1'b0;
        checks++; if (acc_n !== 2 || out_n !== 2) begin
            errors++; $display("FAIL b2b_counts got acc=%0d out=%0d want=2/2", acc_n, out_n); end
        checks++; if (acc_t[1] - acc_t[0] !== 35) begin
            errors++; $display("FAIL b2b_gap got=%0d want=35", acc_t[1] - acc_t[0]); end
        checks++; if (outs[0] !== chacha_ref(sa, 8, 1'b1)) begin
            errors++; $display("FAIL b2b_first got=%h want=%h", outs[0], chacha_ref(sa, 8, 1'b1)); end
        checks++; if (outs[1] !== chacha_ref(sb, 8, 1'b1)) begin
            errors++; $display("FAIL b2b_second got=%h want=%h", outs[1], chacha_ref(sb, 8, 1'b1)); end
        tick();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; in_state = '0;
        iv20 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        or20 = 1'b1; or1 = 1'b1; or8 = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_rfc();
        test_single_round();
        test_stall();
        test_random_r8();
        test_hold();
        test_midreset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
